// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan_driver
// Description : Scans a 16-bit hex value onto a 4-digit multiplexed 7-segment
//               display. The value is snapshotted once per scan frame so a
//               register write in the middle of a frame cannot tear the image.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] data_in,
    input  logic        enable,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam logic [15:0] c_last_count = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  c_an_off     = AN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0]  c_seg_off    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    generate
        if ((SCAN_DIV < 2) || (SCAN_DIV > 65535)) begin : g_bad_scan_div
            $error("sevenseg_scan_driver: SCAN_DIV must be in 2..65535");
        end
    endgenerate

    logic [15:0] r_prescaler;
    logic [1:0]  r_index;
    logic [15:0] r_shadow;
    logic        r_shadow_lz;
    logic        r_frame_tick;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;

    logic        w_tick;
    logic        w_frame;
    logic [3:0]  w_nibble;
    logic [6:0]  w_seg_raw;
    logic [3:0]  w_an_onehot;
    logic        w_blank;

    // The tick already folds in enable, so a disable on the frame edge wins.
    assign w_tick  = enable && (r_prescaler == c_last_count);
    assign w_frame = w_tick && (r_index == 2'd3);

    // Prescaler and digit index; both parked at zero while disabled.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_prescaler <= 16'd0;
            r_index     <= 2'd0;
        end else if (!enable) begin
            r_prescaler <= 16'd0;
            r_index     <= 2'd0;
        end else begin
            r_prescaler <= (r_prescaler == c_last_count) ? 16'd0 : r_prescaler + 16'd1;
            if (w_tick) begin
                r_index <= r_index + 2'd1;
            end
        end
    end

    // Snapshot: tracks the input while dark, otherwise loads once per frame.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_shadow     <= 16'h0000;
            r_shadow_lz  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else if (!enable) begin
            r_shadow     <= data_in;
            r_shadow_lz  <= blank_lz;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame;
            if (w_frame) begin
                r_shadow    <= data_in;
                r_shadow_lz <= blank_lz;
            end
        end
    end

    // Hex decode of the selected nibble plus leading-zero blanking decision.
    always_comb begin
        w_nibble    = r_shadow[{r_index, 2'b00} +: 4];
        w_an_onehot = 4'b0001 << r_index;
        w_seg_raw   = 7'h00;
        w_blank     = 1'b0;
        case (w_nibble)
            4'h0: w_seg_raw = 7'h3F;
            4'h1: w_seg_raw = 7'h06;
            4'h2: w_seg_raw = 7'h5B;
            4'h3: w_seg_raw = 7'h4F;
            4'h4: w_seg_raw = 7'h66;
            4'h5: w_seg_raw = 7'h6D;
            4'h6: w_seg_raw = 7'h7D;
            4'h7: w_seg_raw = 7'h07;
            4'h8: w_seg_raw = 7'h7F;
            4'h9: w_seg_raw = 7'h6F;
            4'hA: w_seg_raw = 7'h77;
            4'hB: w_seg_raw = 7'h7C;
            4'hC: w_seg_raw = 7'h39;
            4'hD: w_seg_raw = 7'h5E;
            4'hE: w_seg_raw = 7'h79;
            default: w_seg_raw = 7'h71;
        endcase
        case (r_index)
            2'd1:    w_blank = r_shadow_lz && (r_shadow[15:4] == 12'h000);
            2'd2:    w_blank = r_shadow_lz && (r_shadow[15:8] == 8'h00);
            2'd3:    w_blank = r_shadow_lz && (r_shadow[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end

    // Registered display outputs with polarity applied; a blanked digit keeps its anode.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_an  <= c_an_off;
            r_seg <= c_seg_off;
        end else if (!enable) begin
            r_an  <= c_an_off;
            r_seg <= c_seg_off;
        end else begin
            r_an  <= AN_ACTIVE_LOW ? ~w_an_onehot : w_an_onehot;
            if (w_blank) begin
                r_seg <= c_seg_off;
            end else begin
                r_seg <= SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
